id_ex_stage: RTL

//  ID/EX pipeline register fed by the instruction decoder/control unit. Captures the decoded

---
 rtl/id_ex_stage.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, EX back-pressure and branch flush.
// Optional bubble counter output stall_cnt when ID_EX_STALL_CNT_EN is defined.
module id_ex_stage #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic                  id_alusrc,
    input  logic [1:0]            id_aluop,
    input  logic                  id_branch,
    input  logic                  id_memwrite,
    input  logic                  id_memtoreg,
    input  logic                  id_regwrite,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [DATA_W-1:0]     id_rs1_data,
    input  logic [DATA_W-1:0]     id_rs2_data,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [DATA_W-1:0]     id_pc,
    input  logic                  ex_stall,
    input  logic                  flush,
    output logic                  id_stall,
    output logic                  ex_valid,
    output logic                  ex_alusrc,
    output logic [1:0]            ex_aluop,
    output logic                  ex_branch,
    output logic                  ex_memwrite,
    output logic                  ex_memtoreg,
    output logic                  ex_regwrite,
    output logic [DATA_W-1:0]     ex_rs1_data,
    output logic [DATA_W-1:0]     ex_rs2_data,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [DATA_W-1:0]     ex_pc,
    output logic [REG_ADDR_W-1:0] ex_rs1,
    output logic [REG_ADDR_W-1:0] ex_rs2,
`ifdef ID_EX_STALL_CNT_EN
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [15:0]           stall_cnt
`else
    output logic [REG_ADDR_W-1:0] ex_rd
`endif
);

    logic                  r_valid;
    logic                  r_alusrc;
    logic [1:0]            r_aluop;
    logic                  r_branch;
    logic                  r_memwrite;
    logic                  r_memtoreg;
    logic                  r_regwrite;
    logic [DATA_W-1:0]     r_rs1_data;
    logic [DATA_W-1:0]     r_rs2_data;
    logic [DATA_W-1:0]     r_imm;
    logic [DATA_W-1:0]     r_pc;
    logic [REG_ADDR_W-1:0] r_rs1;
    logic [REG_ADDR_W-1:0] r_rs2;
    logic [REG_ADDR_W-1:0] r_rd;

    logic w_uses_rs2;
    logic w_load_use;
    logic w_bubble;

    // A load in EX whose destination feeds the ID instruction must be separated by one bubble.
    assign w_uses_rs2 = ~id_alusrc | id_memwrite;
    assign w_load_use = r_valid & r_memtoreg & (r_rd != '0) & id_valid &
                        ((id_rs1 == r_rd) | (w_uses_rs2 & (id_rs2 == r_rd)));
    assign w_bubble   = ~flush & ~ex_stall & w_load_use;
    assign id_stall   = w_load_use | ex_stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_alusrc   <= 1'b0;
            r_aluop    <= 2'b00;
            r_branch   <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_regwrite <= 1'b0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_pc       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
        end else if (flush || (!ex_stall && w_load_use)) begin
            // Kill or bubble: control cleared, data fields left as they were.
            r_valid    <= 1'b0;
            r_alusrc   <= 1'b0;
            r_aluop    <= 2'b00;
            r_branch   <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_regwrite <= 1'b0;
        end else if (!ex_stall) begin
            r_valid    <= id_valid;
            r_alusrc   <= id_valid & id_alusrc;
            r_aluop    <= id_valid ? id_aluop : 2'b00;
            r_branch   <= id_valid & id_branch;
            r_memwrite <= id_valid & id_memwrite;
            r_memtoreg <= id_valid & id_memtoreg;
            r_regwrite <= id_valid & id_regwrite;
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_imm      <= id_imm;
            r_pc       <= id_pc;
            r_rs1      <= id_rs1;
            r_rs2      <= id_rs2;
            r_rd       <= id_rd;
        end
    end

    assign ex_valid    = r_valid;
    assign ex_alusrc   = r_alusrc;
    assign ex_aluop    = r_aluop;
    assign ex_branch   = r_branch;
    assign ex_memwrite = r_memwrite;
    assign ex_memtoreg = r_memtoreg;
    assign ex_regwrite = r_regwrite;
    assign ex_rs1_data = r_rs1_data;
    assign ex_rs2_data = r_rs2_data;
    assign ex_imm      = r_imm;
    assign ex_pc       = r_pc;
    assign ex_rs1      = r_rs1;
    assign ex_rs2      = r_rs2;
    assign ex_rd       = r_rd;

`ifdef ID_EX_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'h0000;
        end else if (w_bubble && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    logic w_unused;
    assign w_unused = w_bubble;
`endif

endmodule
